// File: rtl/uart_pkg.sv
// Shared types and default parameters for the UART transmit path.
// The optional even-parity bit is enabled by defining UART_TX_PARITY_EN.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int UART_DEFAULT_CLKS_PER_BIT = 868;
  localparam int UART_DEFAULT_DEPTH        = 16;

endpackage

// File: rtl/uart_tx_serializer.sv
// Frame serializer: START, 8 data bits LSB first, optional even parity, STOP.
// The parity state exists only when UART_TX_PARITY_EN is defined.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       take,
  output logic       tx,
  output logic       active
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_t        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shreg, shreg_n;
  logic             tx_n;
  logic             baud_done;
`ifdef UART_TX_PARITY_EN
  logic             par, par_n;
`endif

  assign baud_done = (cnt == CNT_LAST);
  // A new byte is only taken when the line is idle or the stop bit is ending,
  // which gives back-to-back frames without an idle gap.
  assign take      = byte_valid && ((state == IDLE) || ((state == STOP) && baud_done));
  assign active    = (state != IDLE);

  always_comb begin
    state_n   = state;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
`ifdef UART_TX_PARITY_EN
    par_n     = par;
`endif
    case (state)
      IDLE: begin
        if (take) begin
          state_n = START;
          shreg_n = byte_in;
`ifdef UART_TX_PARITY_EN
          par_n   = ^byte_in;
`endif
        end
      end
      START: begin
        if (baud_done) begin
          state_n   = DATA;
          bit_idx_n = 3'd0;
        end
      end
      DATA: begin
        if (baud_done) begin
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            shreg_n   = {1'b0, shreg[7:1]};
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_done) state_n = STOP;
      end
`endif
      STOP: begin
        if (baud_done) begin
          if (take) begin
            state_n = START;
            shreg_n = byte_in;
`ifdef UART_TX_PARITY_EN
            par_n   = ^byte_in;
`endif
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    cnt_n = cnt + CNT_W'(1);
    if ((state_n != state) || (state == IDLE)) cnt_n = '0;
  end

  // tx is registered from the next-state view so it changes with the state.
  always_comb begin
    tx_n = 1'b1;
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shreg_n[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_n = par_n;
`endif
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= 3'd0;
      shreg   <= 8'd0;
      tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
      tx      <= tx_n;
`ifdef UART_TX_PARITY_EN
      par     <= par_n;
`endif
    end
  end

endmodule

// File: rtl/uart_tx_buffer.sv
// UART transmit buffer: valid/ready byte FIFO feeding an 8N1 serializer.
// Define UART_TX_PARITY_EN to append an even-parity bit to every frame.
module uart_tx_buffer
  import uart_pkg::*;
#(
  parameter int DEPTH        = UART_DEFAULT_DEPTH,
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [7:0]                 in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       tx,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             push, pop;
  logic             ser_active;

  // Fullness is judged on the registered level, so a same-cycle pop never frees a slot.
  assign in_ready = reset && (level != FULL_LVL);
  assign push     = in_valid && in_ready;
  assign busy     = ser_active || (level != '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  uart_tx_serializer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_serializer (
    .clk       (clk),
    .reset     (reset),
    .byte_in   (mem[rd_ptr]),
    .byte_valid(level != '0),
    .take      (pop),
    .tx        (tx),
    .active    (ser_active)
  );

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed bench for uart_tx_buffer with DEPTH=4, CLKS_PER_BIT=4.
// Define UART_TX_PARITY_EN for both bench and RTL to cover the parity build.
module tb_uart_tx_buffer;

  localparam int CPB = 4;
  localparam int DEP = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FLEN = 11 * CPB;
`else
  localparam int FLEN = 10 * CPB;
`endif
  localparam int STOP_POS = FLEN - CPB;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       tx;
  logic       busy;
  logic [2:0] level;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [7:0] rx_q[$];
  int         rx_start[$];
  logic       par_q[$];
  int         mon_bad = 0;

  uart_tx_buffer #(
    .DEPTH       (DEP),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .tx      (tx),
    .busy    (busy),
    .level   (level)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Line decoder: samples tx mid-cycle, drops any partial frame on reset.
  initial begin
    logic       mon_active;
    int         mon_pos;
    int         mon_start;
    logic [7:0] mon_byte;
    logic       mon_par;
    mon_active = 1'b0;
    mon_pos    = 0;
    mon_start  = 0;
    mon_byte   = 8'd0;
    mon_par    = 1'b0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        mon_active = 1'b0;
      end else if (!mon_active) begin
        if (tx === 1'b0) begin
          mon_active = 1'b1;
          mon_pos    = 0;
          mon_start  = cyc;
          mon_byte   = 8'd0;
        end
      end else begin
        mon_pos++;
        if (mon_pos >= CPB && mon_pos < 9 * CPB && (mon_pos % CPB) == 0)
          mon_byte[mon_pos / CPB - 1] = tx;
        if (mon_pos == 9 * CPB) mon_par = tx;
        if (mon_pos == STOP_POS) begin
          if (tx !== 1'b1) mon_bad++;
          rx_q.push_back(mon_byte);
          rx_start.push_back(mon_start);
          par_q.push_back(mon_par);
        end
        if (mon_pos == FLEN - 1) mon_active = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected tx in cycle i (1-based) of a frame whose START began at cycle 1.
  function automatic logic exp_bit(input logic [7:0] b, input int i);
    int j;
    if (i <= CPB) return 1'b0;
    j = (i - CPB - 1) / CPB;
    if (j < 8) return b[j];
`ifdef UART_TX_PARITY_EN
    if (j == 8) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_idle_in_budget"}, 32'(n < budget), 32'd1);
    tick();
  endtask

  function automatic logic [7:0] rx_at(input int k);
    if (k < rx_q.size()) return rx_q[k];
    return 8'hxx;
  endfunction

  function automatic int gap_at(input int k);
    if (k + 1 < rx_start.size()) return rx_start[k + 1] - rx_start[k];
    return -1;
  endfunction

  task automatic clear_rx();
    rx_q.delete();
    rx_start.delete();
    par_q.delete();
  endtask

  initial begin
    logic [7:0] full_bytes [5];
    int         k;
    int         n;
    int         max_lvl;
    int         hi_err;
    logic       acc;

    full_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // Reset state
    repeat (3) tick();
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    reset = 1'b1;
    tick();
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_tx", 32'(tx), 32'd1);

    // Single byte 0xA5, cycle-accurate waveform
    clear_rx();
    in_data  = 8'hA5;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("a5_level_after_push", 32'(level), 32'd1);
    check("a5_tx_idle_at_push", 32'(tx), 32'd1);
    for (int i = 1; i <= FLEN; i++) begin
      tick();
      check($sformatf("a5_tx_cycle%0d", i), 32'(tx), 32'(exp_bit(8'hA5, i)));
      if (i == 1) check("a5_level_after_pop", 32'(level), 32'd0);
    end
    check("a5_busy_last_stop", 32'(busy), 32'd1);
    tick();
    check("a5_busy_dropped", 32'(busy), 32'd0);
    check("a5_tx_high_after", 32'(tx), 32'd1);
    check("a5_rx_count", 32'(rx_q.size()), 32'd1);
    check("a5_rx_byte", 32'(rx_at(0)), 32'hA5);

    // Full FIFO with serializer busy
    clear_rx();
    k = 0;
    n = 0;
    while (k < 5 && n < 20) begin
      in_data  = full_bytes[k];
      in_valid = 1'b1;
      acc      = in_ready;
      tick();
      if (acc) k++;
      n++;
    end
    check("full_pushes_accepted", 32'(k), 32'd5);
    in_data = 8'h77;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("full_level_%0d", i), 32'(level), 32'd4);
      check($sformatf("full_in_ready_%0d", i), 32'(in_ready), 32'd0);
      tick();
    end
    in_valid = 1'b0;
    wait_idle("full", 400);
    check("full_rx_count", 32'(rx_q.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      check($sformatf("full_rx_byte%0d", i), 32'(rx_at(i)), 32'(full_bytes[i]));
    for (int i = 0; i < 4; i++)
      check($sformatf("full_gap%0d", i), 32'(gap_at(i)), 32'(FLEN));

    // Back-to-back 0x00, 0xFF
    clear_rx();
    in_data  = 8'h00;
    in_valid = 1'b1;
    tick();
    in_data  = 8'hFF;
    tick();
    in_valid = 1'b0;
    wait_idle("b2b", 200);
    check("b2b_rx_count", 32'(rx_q.size()), 32'd2);
    check("b2b_rx_byte0", 32'(rx_at(0)), 32'h00);
    check("b2b_rx_byte1", 32'(rx_at(1)), 32'hFF);
    check("b2b_gap", 32'(gap_at(0)), 32'(FLEN));

    // Wrap-around stream 0x10..0x19
    clear_rx();
    k = 0;
    n = 0;
    max_lvl = 0;
    while (k < 10 && n < 1000) begin
      in_data  = 8'h10 + 8'(k);
      in_valid = 1'b1;
      acc      = in_ready;
      tick();
      if (acc) k++;
      if (int'(level) > max_lvl) max_lvl = int'(level);
      n++;
    end
    in_valid = 1'b0;
    check("wrap_pushes_accepted", 32'(k), 32'd10);
    wait_idle("wrap", 600);
    check("wrap_max_level", 32'(max_lvl), 32'd4);
    check("wrap_rx_count", 32'(rx_q.size()), 32'd10);
    for (int i = 0; i < 10; i++)
      check($sformatf("wrap_rx_byte%0d", i), 32'(rx_at(i)), 32'h10 + 32'(i));

    // Reset in DATA bit 3 of 0x3C with a second byte queued
    clear_rx();
    in_data  = 8'h3C;
    in_valid = 1'b1;
    tick();
    in_data  = 8'h5A;
    tick();
    in_valid = 1'b0;
    repeat (17) tick();
    check("rstmid_tx_bit3", 32'(tx), 32'd1);
    check("rstmid_level_before", 32'(level), 32'd1);
    reset = 1'b0;
    tick();
    check("rstmid_tx", 32'(tx), 32'd1);
    check("rstmid_level", 32'(level), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_in_ready", 32'(in_ready), 32'd0);
    reset = 1'b1;
    hi_err = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (tx !== 1'b1) hi_err++;
    end
    check("rstmid_no_remnant", 32'(hi_err), 32'd0);
    check("rstmid_rx_count", 32'(rx_q.size()), 32'd0);
    check("rstmid_busy_after", 32'(busy), 32'd0);

`ifdef UART_TX_PARITY_EN
    // Even parity: 0x07 -> 1, 0x03 -> 0
    clear_rx();
    in_data  = 8'h07;
    in_valid = 1'b1;
    tick();
    in_data  = 8'h03;
    tick();
    in_valid = 1'b0;
    wait_idle("par", 200);
    check("par_rx_count", 32'(rx_q.size()), 32'd2);
    check("par_rx_byte0", 32'(rx_at(0)), 32'h07);
    check("par_rx_byte1", 32'(rx_at(1)), 32'h03);
    check("par_bit0", 32'(par_q.size() > 0 ? par_q[0] : 1'bx), 32'd1);
    check("par_bit1", 32'(par_q.size() > 1 ? par_q[1] : 1'bx), 32'd0);
    check("par_frame_len", 32'(gap_at(0)), 32'd44);
`endif

    check("stop_bits_high", 32'(mon_bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
